// File: rtl/ddr3_rd_sched.sv
// Round-robin scheduler moving 36-bit DDR3 read descriptors from NUM_REQ requesters into
// the shared read-descriptor FIFO, with per-requester credits, hold-off and optional ECM priority.
module ddr3_rd_sched #(
    parameter  int NUM_REQ    = 4,
    parameter  int MAX_OUTST  = 4,
    parameter  int CNT_W      = 3,
    parameter  int GAP_CYCLES = 2,
    parameter  int PRIO0      = 1,
    localparam int ID_W       = $clog2(NUM_REQ),
    localparam int DESC_W     = 36
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [DESC_W*NUM_REQ-1:0] req_desc,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_hold,
    input  logic [NUM_REQ-1:0]        req_done,
    input  logic                      rd_fifo_wfull,
    output logic                      rd_fifo_wreq,
    output logic [DESC_W-1:0]         rd_fifo_wdata,
    output logic [ID_W-1:0]           rd_grant_id,
    output logic                      sched_busy,
    output logic                      err_underflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [2:0]        gap_cnt;
    logic [CNT_W-1:0]  outst [NUM_REQ];
    logic [NUM_REQ-1:0] eligible;
    logic [ID_W-1:0]   win_id;
    logic              accept;
    logic              fifo_write;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] & ~req_hold[i] & (outst[i] < CNT_W'(MAX_OUTST));
        end
    end

    // Requester 0 pre-empts the rotation when priority is enabled; otherwise search from rr_ptr.
    always_comb begin : pick_winner
        logic            found;
        logic [ID_W-1:0] idx;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        found  = 1'b0;
        win_id = '0;
        idx    = '0;
        if (PRIO0 != 0 && eligible[0]) begin
            found = 1'b1;
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = rr_ptr + ID_W'(k);
            if (!found && eligible[idx]) begin
                win_id = idx;
                found  = 1'b1;
            end
        end
    end

    assign accept        = (state == IDLE) && (|eligible) && !reset;
    assign req_ready     = accept ? (NUM_REQ'(1) << win_id) : '0;
    assign fifo_write    = (state == ISSUE) && !rd_fifo_wfull && !reset;
    assign rd_fifo_wreq  = fifo_write;
    assign sched_busy    = (state != IDLE);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            gap_cnt       <= '0;
            rd_fifo_wdata <= '0;
            rd_grant_id   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rd_fifo_wdata <= req_desc[DESC_W*win_id +: DESC_W];
                        rd_grant_id   <= win_id;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (fifo_write) begin
                        rr_ptr <= rd_grant_id + 1'b1;
                        if (GAP_CYCLES > 0) begin
                            state   <= GAP;
                            gap_cnt <= 3'(GAP_CYCLES - 1);
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A done with no credit outstanding is flagged and ignored; an accept in the same cycle still counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the credit array is a handful of flops, not a RAM, so it is reset explicitly.
            for (int i = 0; i < NUM_REQ; i++) begin
                outst[i] <= '0;
            end
            err_underflow <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_done[i] && outst[i] == '0) begin
                    err_underflow <= 1'b1;
                    if (req_ready[i]) begin
                        outst[i] <= CNT_W'(1);
                    end
                end else if (req_ready[i] && !req_done[i]) begin
                    outst[i] <= outst[i] + 1'b1;
                end else if (!req_ready[i] && req_done[i]) begin
                    outst[i] <= outst[i] - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ddr3_rd_sched.sv
// Scoreboard bench for ddr3_rd_sched: stimulus pushes expected FIFO writes, a monitor pops them.
// A second instance with PRIO0=0 exercises pure round-robin ordering and issue spacing.
module tb_ddr3_rd_sched;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [3:0]   req_valid, req_hold, req_done, req_ready;
    logic [143:0] req_desc;
    logic         rd_fifo_wfull, rd_fifo_wreq;
    logic [35:0]  rd_fifo_wdata;
    logic [1:0]   rd_grant_id;
    logic         sched_busy, err_underflow;

    logic [3:0]   rr_valid, rr_ready;
    logic [143:0] rr_desc;
    logic         rr_wreq, rr_busy, rr_err;
    logic [35:0]  rr_wdata;
    logic [1:0]   rr_gid;

    ddr3_rd_sched #(.PRIO0(1)) u_dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_desc      (req_desc),
        .req_ready     (req_ready),
        .req_hold      (req_hold),
        .req_done      (req_done),
        .rd_fifo_wfull (rd_fifo_wfull),
        .rd_fifo_wreq  (rd_fifo_wreq),
        .rd_fifo_wdata (rd_fifo_wdata),
        .rd_grant_id   (rd_grant_id),
        .sched_busy    (sched_busy),
        .err_underflow (err_underflow)
    );

    ddr3_rd_sched #(.PRIO0(0)) u_rr (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (rr_valid),
        .req_desc      (rr_desc),
        .req_ready     (rr_ready),
        .req_hold      (4'b0000),
        .req_done      (4'b0000),
        .rd_fifo_wfull (1'b0),
        .rd_fifo_wreq  (rr_wreq),
        .rd_fifo_wdata (rr_wdata),
        .rd_grant_id   (rr_gid),
        .sched_busy    (rr_busy),
        .err_underflow (rr_err)
    );

    typedef struct packed {
        logic [1:0]  id;
        logic [35:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        rr_q[$];
    exp_t        mon_e, rr_e;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          rr_last = -1;
    int          seq[4];
    int          rr_seq[4];
    logic [35:0] last_exp;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [35:0] mk(input logic [3:0] tag, input int id, input int n);
        return {tag, 4'(id), 28'(n)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every FIFO write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rd_fifo_wreq === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("dut_wreq_expected", 64'(exp_q.size() != 0), 64'd1);
            end else begin
                mon_e = exp_q.pop_front();
                check("dut_wr_id", 64'(rd_grant_id), 64'(mon_e.id));
                check("dut_wr_data", 64'(rd_fifo_wdata), 64'(mon_e.data));
            end
        end
        if (rr_wreq === 1'b1) begin
            if (rr_q.size() == 0) begin
                check("rr_wreq_expected", 64'(rr_q.size() != 0), 64'd1);
            end else begin
                rr_e = rr_q.pop_front();
                check("rr_wr_id", 64'(rr_gid), 64'(rr_e.id));
                check("rr_wr_data", 64'(rr_wdata), 64'(rr_e.data));
            end
            if (rr_last >= 0) check("rr_spacing", 64'(cyc - rr_last), 64'd4);
            rr_last = cyc;
        end
    end

    // Waits (bounded) for the next accept, checks it is the expected one-hot, queues the write.
    task automatic do_accept(input bit on_rr, input int id, input bit push, input string name);
        logic [3:0]  seen;
        logic [35:0] d;
        bit          got;
        exp_t        e;
        seen = '0;
        got  = 1'b0;
        d    = on_rr ? rr_desc[36*id +: 36] : req_desc[36*id +: 36];
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            seen = on_rr ? rr_ready : req_ready;
            got  = (seen != 4'b0000);
        end
        check(name, 64'(seen), 64'(4'b0001 << id));
        if (got && seen == (4'b0001 << id) && push) begin
            e.id   = 2'(id);
            e.data = d;
            if (on_rr) rr_q.push_back(e);
            else       exp_q.push_back(e);
        end
        last_exp = d;
        step();
        if (on_rr) begin
            rr_seq[id]++;
            rr_desc[36*id +: 36] = mk(4'hE, id, rr_seq[id]);
        end else begin
            seq[id]++;
            req_desc[36*id +: 36] = mk(4'hD, id, seq[id]);
        end
    endtask

    task automatic no_accept(input int n, input string name);
        int hits;
        hits = 0;
        repeat (n) begin
            @(negedge clk);
            if (req_ready != 4'b0000) hits++;
        end
        check(name, 64'(hits), 64'd0);
    endtask

    task automatic pulse_done(input logic [3:0] mask, input int n);
        step();
        req_done = mask;
        repeat (n) step();
        req_done = 4'b0000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        req_valid     = '0;
        req_hold      = '0;
        req_done      = '0;
        rd_fifo_wfull = 1'b0;
        rr_valid      = '0;
        for (int i = 0; i < 4; i++) begin
            seq[i]    = 0;
            rr_seq[i] = 0;
            req_desc[36*i +: 36] = mk(4'hD, i, 0);
            rr_desc[36*i +: 36]  = mk(4'hE, i, 0);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_wreq", 64'(rd_fifo_wreq), 64'd0);
        check("rst_wdata", 64'(rd_fifo_wdata), 64'd0);
        check("rst_grant_id", 64'(rd_grant_id), 64'd0);
        check("rst_busy", 64'(sched_busy), 64'd0);
        check("rst_err", 64'(err_underflow), 64'd0);
        step();
        reset = 1'b0;

        // Pure round-robin: all valid, grants 0,1,2,3,0,1,2,3 spaced 4 cycles.
        rr_valid = 4'hF;
        for (int r = 0; r < 8; r++) do_accept(1'b1, r % 4, 1'b1, "rr_grant");
        rr_valid = '0;

        // Priority: rr_ptr moved to 2 by granting req 1, then req 0 still wins over req 2.
        req_valid = 4'b0010;
        do_accept(1'b0, 1, 1'b1, "prio_setup");
        req_valid = 4'b0101;
        do_accept(1'b0, 0, 1'b1, "prio_req0_first");
        req_valid = 4'b0100;
        do_accept(1'b0, 2, 1'b1, "prio_req2_next");
        req_valid = '0;
        pulse_done(4'b0111, 1);
        @(negedge clk);
        check("no_underflow", 64'(err_underflow), 64'd0);

        // Credit limit on req 1.
        req_valid = 4'b0010;
        repeat (4) do_accept(1'b0, 1, 1'b1, "credit_accept");
        no_accept(16, "credit_block");
        pulse_done(4'b0010, 1);
        do_accept(1'b0, 1, 1'b1, "credit_after_done");
        no_accept(12, "credit_block_again");
        req_valid = '0;
        pulse_done(4'b0010, 4);

        // FIFO full while in ISSUE.
        step();
        rd_fifo_wfull = 1'b1;
        req_valid     = 4'b0001;
        do_accept(1'b0, 0, 1'b1, "full_accept");
        req_valid = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("full_wreq_low", 64'(rd_fifo_wreq), 64'd0);
            check("full_wdata_stable", 64'(rd_fifo_wdata), 64'(last_exp));
            check("full_busy", 64'(sched_busy), 64'd1);
        end
        step();
        rd_fifo_wfull = 1'b0;
        @(negedge clk);
        check("full_release_wreq", 64'(rd_fifo_wreq), 64'd1);

        // Hold-off and underflow.
        step();
        req_hold  = 4'b1000;
        req_valid = 4'b1000;
        no_accept(15, "hold_blocks");
        step();
        req_valid = 4'b1100;
        do_accept(1'b0, 2, 1'b1, "hold_others_run");
        req_valid = 4'b1000;
        no_accept(10, "hold_still_blocks");
        req_valid = '0;
        req_hold  = '0;
        pulse_done(4'b0100, 1);
        @(negedge clk);
        check("underflow_clear", 64'(err_underflow), 64'd0);
        pulse_done(4'b0100, 1);
        @(negedge clk);
        check("underflow_set", 64'(err_underflow), 64'd1);
        step();
        req_valid = 4'b0100;
        repeat (4) do_accept(1'b0, 2, 1'b1, "underflow_cnt_zero");
        no_accept(12, "underflow_cnt_limit");
        req_valid = '0;
        check("underflow_sticky", 64'(err_underflow), 64'd1);

        // Reset while a descriptor sits in ISSUE: dropped, credits and rr_ptr cleared.
        step();
        req_valid = 4'b1000;
        do_accept(1'b0, 3, 1'b0, "reset_accept");
        reset     = 1'b1;
        req_valid = '0;
        @(negedge clk);
        check("reset_no_wreq", 64'(rd_fifo_wreq), 64'd0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("reset_err_clear", 64'(err_underflow), 64'd0);
        check("reset_busy", 64'(sched_busy), 64'd0);
        step();
        req_valid = 4'b1010;
        do_accept(1'b0, 1, 1'b1, "reset_rr_order");
        req_valid = 4'b1000;
        do_accept(1'b0, 3, 1'b1, "reset_next");
        req_valid = 4'b0100;
        repeat (4) do_accept(1'b0, 2, 1'b1, "reset_credits_cleared");
        req_valid = '0;

        repeat (20) @(negedge clk);
        check("dut_drain", 64'(exp_q.size()), 64'd0);
        check("rr_drain", 64'(rr_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
